// File: rtl/trade_executor.sv
// Order executor for a one-unit long position: turns buy/sell levels into BUY/SELL orders,
// then tracks entry price, realized P&L, round-trip count, a post-exit cooldown and an optional stop-loss.
module trade_executor #(
  parameter int unsigned COOLDOWN_CYC = 16,
  parameter logic [15:0] STOP_LOSS    = 16'd0,
  parameter int unsigned PNL_W        = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [15:0]             price_now,
  input  logic                    buy,
  input  logic                    sell,
  input  logic                    order_ready,
  output logic                    order_valid,
  output logic                    order_side,
  output logic [15:0]             order_price,
  output logic                    position,
  output logic [15:0]             entry_price,
  output logic signed [PNL_W-1:0] realized_pnl,
  output logic [15:0]             trade_count,
  output logic                    in_cooldown,
  output logic [2:0]              dbg_state
);

  // Order port: an order transfers on the rising edge where order_valid and order_ready are
  // both high. order_side/order_price stay stable while order_valid is high.

  localparam logic [2:0] S_FLAT     = 3'd0;
  localparam logic [2:0] S_BUY_REQ  = 3'd1;
  localparam logic [2:0] S_LONG     = 3'd2;
  localparam logic [2:0] S_SELL_REQ = 3'd3;
  localparam logic [2:0] S_COOL     = 3'd4;

  localparam int unsigned    CW        = (COOLDOWN_CYC < 2) ? 1 : $clog2(COOLDOWN_CYC + 1);
  localparam logic [CW-1:0]  COOL_LOAD = CW'(COOLDOWN_CYC);
  localparam logic [PNL_W-1:0] PNL_MAX = {1'b0, {(PNL_W-1){1'b1}}};
  localparam logic [PNL_W-1:0] PNL_MIN = {1'b1, {(PNL_W-1){1'b0}}};

  logic [2:0]       state;
  logic [CW-1:0]    cool_cnt;
  logic             buy_go;
  logic             sell_go;
  logic             stop_hit;
  logic [16:0]      pnl_delta;
  logic [PNL_W:0]   pnl_sum;
  logic [PNL_W-1:0] pnl_next;

  always_comb begin
    buy_go    = buy & ~sell;
    sell_go   = sell & ~buy;
    stop_hit  = (STOP_LOSS != 16'd0) &&
                (({1'b0, price_now} + {1'b0, STOP_LOSS}) <= {1'b0, entry_price});
    // 17-bit two's-complement difference, sign-extended into one guard bit above the P&L
    pnl_delta = {1'b0, order_price} - {1'b0, entry_price};
    pnl_sum   = {realized_pnl[PNL_W-1], realized_pnl} + {{(PNL_W-16){pnl_delta[16]}}, pnl_delta};
    if (pnl_sum[PNL_W] != pnl_sum[PNL_W-1]) begin
      pnl_next = pnl_sum[PNL_W] ? PNL_MIN : PNL_MAX;
    end else begin
      pnl_next = pnl_sum[PNL_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= S_FLAT;
      cool_cnt     <= '0;
      order_valid  <= 1'b0;
      order_side   <= 1'b0;
      order_price  <= 16'd0;
      position     <= 1'b0;
      entry_price  <= 16'd0;
      realized_pnl <= '0;
      trade_count  <= 16'd0;
    end else begin
      case (state)
        S_FLAT: begin
          if (buy_go) begin
            order_price <= price_now;
            order_side  <= 1'b1;
            order_valid <= 1'b1;
            state       <= S_BUY_REQ;
          end
        end
        S_BUY_REQ: begin
          if (order_ready) begin
            order_valid <= 1'b0;
            position    <= 1'b1;
            entry_price <= order_price;
            state       <= S_LONG;
          end
        end
        S_LONG: begin
          if (sell_go || stop_hit) begin
            order_price <= price_now;
            order_side  <= 1'b0;
            order_valid <= 1'b1;
            state       <= S_SELL_REQ;
          end
        end
        S_SELL_REQ: begin
          if (order_ready) begin
            order_valid  <= 1'b0;
            position     <= 1'b0;
            realized_pnl <= pnl_next;
            if (trade_count != 16'hFFFF) trade_count <= trade_count + 16'd1;
            if (COOLDOWN_CYC == 0) begin
              state <= S_FLAT;
            end else begin
              cool_cnt <= COOL_LOAD;
              state    <= S_COOL;
            end
          end
        end
        S_COOL: begin
          // Leaving on the count of one gives exactly COOLDOWN_CYC cycles in this state
          if (cool_cnt == CW'(1)) state <= S_FLAT;
          cool_cnt <= cool_cnt - CW'(1);
        end
        default: state <= S_FLAT;
      endcase
    end
  end

  assign in_cooldown = (state == S_COOL);
  assign dbg_state   = state;

endmodule
